osc_bank_meter: RTL and testbench

//   Next-generation oscillator block: controls N_CH ring-oscillator macros and measures their frequency.
//   - Drives each macro's enable; forwards the selected oscillator, gated by its enable, to a probe output.
//   - Counts the selected oscillator's rising edges over a programmable window of wb_clk_i cycles.
//   - Supports single-shot and continuous measurement. Sits between the wishbone CSR block and the macros.

---
 rtl/osc_bank_meter_pkg.sv | 18 +
 rtl/osc_sync_edge.sv | 19 +
 rtl/osc_bank_meter.sv | 157 +++++++++++++++
 tb/tb_osc_bank_meter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/osc_bank_meter_pkg.sv
// Shared types and helpers for the oscillator bank frequency meter.
package osc_bank_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // The synchronizer needs at least three cycles to flush stale history.
  localparam int MIN_SETTLE_CYC = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/osc_sync_edge.sv
// Two-flop synchronizer on the muxed oscillator plus a rising-edge detector.
module osc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic [2:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], sig};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/osc_bank_meter.sv
// Ring-oscillator bank controller: drives macro enables, forwards the selected
// oscillator to a probe pin and counts its edges over a programmable window.
module osc_bank_meter
  import osc_bank_meter_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int GATE_W     = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   osc_sig_i,
  input  logic [N_CH-1:0]   ch_en_i,
  input  logic [CH_W-1:0]   sel_i,
  input  logic [GATE_W-1:0] gate_len_i,
  input  logic              cont_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [N_CH-1:0]   osc_en_o,
  (* clkbuf_inhibit *)
  output logic              osc_out_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o,
  output logic              err_o
);

  localparam int TMR_W = max_int(GATE_W, $clog2(SETTLE_CYC + 1));

  if (SETTLE_CYC < MIN_SETTLE_CYC) begin : g_settle_chk
    $error("osc_bank_meter: SETTLE_CYC must be >= 3");
  end

  state_t            state, state_nx;
  logic [CH_W-1:0]   sel_q;
  logic [GATE_W-1:0] gate_q;
  logic              cont_q;
  logic [TMR_W-1:0]  tmr;
  logic [CNT_W-1:0]  edge_cnt;
  logic [N_CH-1:0]   force_en;
  logic              mux_out;
  logic              rise;
  logic              req_ok;
  logic              rearm_ok;

  assign req_ok   = (int'(sel_i) < N_CH) && (gate_len_i != '0);
  assign rearm_ok = (gate_len_i != '0);
  assign busy_o   = (state == ST_SETTLE) || (state == ST_MEASURE) ||
                    ((state == ST_DONE) && cont_q);

  always_comb begin
    force_en = '0;
    mux_out  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      force_en[i] = busy_o && (int'(sel_q) == i);
      if (int'(sel_q) == i) mux_out = osc_sig_i[i] & osc_en_o[i];
    end
  end

  assign osc_out_o = mux_out;

  // Enables reset asynchronously so the macros stop the moment rst_n drops.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) osc_en_o <= '0;
    else        osc_en_o <= ch_en_i | force_en;
  end

  osc_sync_edge u_sync (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .sig   (mux_out),
    .rise  (rise)
  );

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start_i && req_ok) state_nx = ST_SETTLE;
      ST_SETTLE:  if (tmr == '0) state_nx = ST_MEASURE;
      ST_MEASURE: if (tmr == '0) state_nx = ST_DONE;
      ST_DONE:    state_nx = (cont_q && rearm_ok) ? ST_MEASURE : ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (stop_i) state_nx = ST_IDLE;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      gate_q   <= '0;
      cont_q   <= 1'b0;
      tmr      <= '0;
      edge_cnt <= '0;
      done_o   <= 1'b0;
      count_o  <= '0;
      ovf_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (!stop_i) begin
        case (state)
          ST_IDLE: begin
            if (start_i && req_ok) begin
              sel_q  <= sel_i;
              gate_q <= gate_len_i;
              cont_q <= cont_i;
              err_o  <= 1'b0;
              tmr    <= TMR_W'(SETTLE_CYC - 1);
            end else if (start_i) begin
              err_o   <= 1'b1;
              done_o  <= 1'b1;
              count_o <= '0;
              ovf_o   <= 1'b0;
            end
          end
          ST_SETTLE: begin
            if (tmr == '0) begin
              tmr      <= TMR_W'(gate_q) - TMR_W'(1);
              edge_cnt <= '0;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          ST_MEASURE: begin
            tmr <= tmr - TMR_W'(1);
            if (rise && !(&edge_cnt)) edge_cnt <= edge_cnt + CNT_W'(1);
          end
          ST_DONE: begin
            count_o <= edge_cnt;
            ovf_o   <= &edge_cnt;
            done_o  <= 1'b1;
            if (cont_q) begin
              gate_q <= gate_len_i;
              if (rearm_ok) begin
                tmr      <= TMR_W'(gate_len_i) - TMR_W'(1);
                edge_cnt <= '0;
              end else begin
                err_o <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osc_bank_meter.sv
// Directed plus randomized bench for osc_bank_meter against an arithmetic frequency model.
module tb_osc_bank_meter;
  localparam int N_CH = 4, CH_W = 2, GATE_W = 16, CNT_W = 16, SETTLE_CYC = 16;
  localparam int NB_CH = 3, NB_CNT_W = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N_CH-1:0]   osc_sig = '0, ch_en = '0;
  logic [CH_W-1:0]   sel = '0;
  logic [GATE_W-1:0] gate_len = '0;
  logic cont = 1'b0, start_a = 1'b0, start_b = 1'b0, stop = 1'b0;

  logic [N_CH-1:0]  a_osc_en;
  logic             a_osc_out, a_busy, a_done, a_ovf, a_err;
  logic [CNT_W-1:0] a_count;
  logic [NB_CH-1:0]    b_osc_en;
  logic                b_osc_out, b_busy, b_done, b_ovf, b_err;
  logic [NB_CNT_W-1:0] b_count;

  int total = 0, bad = 0;
  int half [N_CH] = '{2, 4, 3, 5};
  int phase[N_CH] = '{default: 0};

  osc_bank_meter #(.N_CH(N_CH), .CH_W(CH_W), .GATE_W(GATE_W), .CNT_W(CNT_W),
                   .SETTLE_CYC(SETTLE_CYC)) u_dut_a (
    .wb_clk_i(clk), .rst_n(rst_n), .osc_sig_i(osc_sig), .ch_en_i(ch_en), .sel_i(sel),
    .gate_len_i(gate_len), .cont_i(cont), .start_i(start_a), .stop_i(stop),
    .osc_en_o(a_osc_en), .osc_out_o(a_osc_out), .busy_o(a_busy), .done_o(a_done),
    .count_o(a_count), .ovf_o(a_ovf), .err_o(a_err));

  osc_bank_meter #(.N_CH(NB_CH), .CH_W(CH_W), .GATE_W(GATE_W), .CNT_W(NB_CNT_W),
                   .SETTLE_CYC(SETTLE_CYC)) u_dut_b (
    .wb_clk_i(clk), .rst_n(rst_n), .osc_sig_i(osc_sig[NB_CH-1:0]), .ch_en_i(ch_en[NB_CH-1:0]),
    .sel_i(sel), .gate_len_i(gate_len), .cont_i(cont), .start_i(start_b), .stop_i(stop),
    .osc_en_o(b_osc_en), .osc_out_o(b_osc_out), .busy_o(b_busy), .done_o(b_done),
    .count_o(b_count), .ovf_o(b_ovf), .err_o(b_err));

  always #5 clk = ~clk;

  // Free-running square-wave oscillators, period 2*half[i] clocks, stepped on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      phase[i] = phase[i] + 1;
      if (phase[i] >= half[i]) begin
        phase[i]   = 0;
        osc_sig[i] = ~osc_sig[i];
      end
    end
  end

  function automatic int exp_latency(input int g);
    return 2 + SETTLE_CYC + g;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [63:0] obs, input int lo, input int hi);
    total++;
    assert (obs >= 64'(lo) && obs <= 64'(hi)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on A or B and returns the number of edges until done_o is seen.
  task automatic run_to_done(input bit on_b, input int bound, output int lat);
    if (on_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 1;
    while (!(on_b ? b_done : a_done) && lat < bound) begin
      tick();
      lat++;
    end
    check("done_seen", on_b ? b_done : a_done, 1'b1);
  endtask

  initial begin
    int lat, n_done, ch, g, p;
    logic [N_CH-1:0] en_mask;

    // Reset state
    tick();
    check("rst_osc_en", a_osc_en, '0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_count", a_count, '0);
    check("rst_err", a_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_busy", a_busy, 1'b0);

    // Single shot on ch1 (period 8) with a colliding start and a ch_en change mid-run
    sel = 2'd1; gate_len = 16'd64; cont = 1'b0; ch_en = '0;
    start_a = 1'b1; tick(); start_a = 1'b0; lat = 1;
    tick(); lat++;
    check("single_busy", a_busy, 1'b1);
    check("single_force_en", a_osc_en, 4'b0010);
    check("single_probe", a_osc_out, osc_sig[1]);
    sel = 2'd2; gate_len = 16'd10; start_a = 1'b1; tick(); lat++; start_a = 1'b0;
    ch_en = 4'b1000; tick(); lat++;
    tick(); lat++;
    check("collision_sel_hold", a_osc_en, 4'b1010);
    while (!a_done && lat < 300) begin tick(); lat++; end
    check("done_seen", a_done, 1'b1);
    check("single_latency", lat, exp_latency(64));
    check_rng("single_count", a_count, 64 / 8, (64 + 7) / 8);
    check("single_ovf", a_ovf, 1'b0);
    check("single_busy_end", a_busy, 1'b0);
    check("single_release_en", a_osc_en, 4'b1000);
    check("single_probe_off", a_osc_out, 1'b0);

    // Continuous on ch0 (period 4), gate 32
    sel = 2'd0; gate_len = 16'd32; cont = 1'b1; ch_en = '0;
    run_to_done(1'b0, 300, lat);
    check("cont_first_latency", lat, exp_latency(32));
    for (int w = 0; w < 3; w++) begin
      check("cont_count", a_count, 32 / 4);
      check("cont_busy", a_busy, 1'b1);
      lat = 0;
      do begin tick(); lat++; end while (!a_done && lat < 100);
      check("cont_period", lat, 32 + 1);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_busy", a_busy, 1'b0);
    n_done = 0;
    repeat (80) begin tick(); if (a_done) n_done++; end
    check("stop_no_done", n_done, 0);
    check("stop_count_hold", a_count, 8);
    check("stop_release_en", a_osc_en, '0);

    // Randomized single shots vs. arithmetic count model
    for (int k = 0; k < 6; k++) begin
      ch = $urandom_range(0, N_CH - 1);
      g  = $urandom_range(16, 90);
      p  = 2 * half[ch];
      en_mask = N_CH'($urandom);
      sel = CH_W'(ch); gate_len = GATE_W'(g); cont = 1'b0; ch_en = en_mask;
      run_to_done(1'b0, 300, lat);
      check("rand_latency", lat, exp_latency(g));
      check_rng("rand_count", a_count, g / p, (g + p - 1) / p);
      check("rand_ovf", a_ovf, 1'b0);
      check("rand_err", a_err, 1'b0);
      check("rand_en", a_osc_en, en_mask);
    end

    // Invalid start: gate 0
    gate_len = '0; cont = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("inv_gate_err", a_err, 1'b1);
    check("inv_gate_done", a_done, 1'b1);
    check("inv_gate_count", a_count, '0);
    check("inv_gate_busy", a_busy, 1'b0);
    tick();
    check("inv_gate_done_pulse", a_done, 1'b0);

    // Continuous re-arm sampling gate 0 ends with err, ch2 period 6, gate 30
    sel = 2'd2; gate_len = 16'd30; cont = 1'b1; ch_en = '0;
    start_a = 1'b1; tick(); start_a = 1'b0; gate_len = '0; lat = 1;
    while (!a_done && lat < 300) begin tick(); lat++; end
    check("rearm_latency", lat, exp_latency(30));
    check("rearm_count", a_count, 30 / 6);
    check("rearm_err", a_err, 1'b1);
    check("rearm_busy", a_busy, 1'b0);

    // start and stop together, then stop during settle
    sel = 2'd1; gate_len = 16'd20; cont = 1'b0;
    start_a = 1'b1; stop = 1'b1; tick(); start_a = 1'b0; stop = 1'b0;
    check("start_stop_busy", a_busy, 1'b0);
    check("start_stop_err_hold", a_err, 1'b1);
    start_a = 1'b1; tick(); start_a = 1'b0; tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_settle_busy", a_busy, 1'b0);
    tick();
    check("stop_settle_en", a_osc_en, '0);

    // Asynchronous reset mid-measurement
    sel = 2'd3; gate_len = 16'd100; cont = 1'b0; ch_en = 4'b0101;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (40) tick();
    check("pre_rst_busy", a_busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_osc_en", a_osc_en, '0);
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_probe", a_osc_out, 1'b0);
    check("mid_rst_count", a_count, '0);
    check("mid_rst_err", a_err, 1'b0);
    tick();
    rst_n = 1'b1; ch_en = '0;
    n_done = 0;
    repeat (10) begin tick(); if (a_busy || a_done) n_done++; end
    check("post_rst_idle", n_done, 0);

    // Saturation on the narrow-counter instance: ch0 period 4, gate 200
    sel = 2'd0; gate_len = 16'd200; cont = 1'b0;
    run_to_done(1'b1, 400, lat);
    check("sat_latency", lat, exp_latency(200));
    check("sat_count", b_count, (1 << NB_CNT_W) - 1);
    check("sat_ovf", b_ovf, 1'b1);

    // Out-of-range select on the 3-channel instance
    sel = 2'd3; gate_len = 16'd20;
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("inv_sel_err", b_err, 1'b1);
    check("inv_sel_done", b_done, 1'b1);
    check("inv_sel_count", b_count, '0);
    check("inv_sel_ovf", b_ovf, 1'b0);
    check("inv_sel_busy", b_busy, 1'b0);
    check("inv_sel_a_quiet", a_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
